// File: rtl/y86_pkg.sv
// Shared Y86 definitions: register codes, write-back scheduler state and the
// register-write record used for the held second write of a pair.
package y86_pkg;

    localparam int       XLEN  = 64;
    localparam logic [3:0] RNONE = 4'hF;

    // Architectural register indices
    localparam logic [3:0] RAX = 4'd0;
    localparam logic [3:0] RCX = 4'd1;
    localparam logic [3:0] RDX = 4'd2;
    localparam logic [3:0] RBX = 4'd3;
    localparam logic [3:0] RSP = 4'd4;
    localparam logic [3:0] RBP = 4'd5;
    localparam logic [3:0] RSI = 4'd6;
    localparam logic [3:0] RDI = 4'd7;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } wbs_state_t;

    typedef struct packed {
        logic [3:0]      addr;
        logic [XLEN-1:0] data;
    } reg_write_t;

endpackage

// File: rtl/y86_sb_counter.sv
// One scoreboard entry: 2-bit saturating up/down counter. Simultaneous inc
// and dec cancel. Saturating at either end raises a sticky err.
module y86_sb_counter (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic err
);

    logic [1:0] cnt_reg;
    logic       err_reg;

    // Count outstanding writes; flag overflow/underflow without wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= 2'd0;
            err_reg <= 1'b0;
        end else begin
            if (inc && !dec) begin
                if (cnt_reg == 2'd3) err_reg <= 1'b1;
                else                 cnt_reg <= cnt_reg + 2'd1;
            end else if (dec && !inc) begin
                if (cnt_reg == 2'd0) err_reg <= 1'b1;
                else                 cnt_reg <= cnt_reg - 2'd1;
            end
        end
    end

    assign nonzero = (cnt_reg != 2'd0);
    assign err     = err_reg;

endmodule

// File: rtl/y86_wb_sched.sv
// Write-back scheduler: serialises the valE/valM pair of one instruction onto
// the single register-file write port and keeps a per-register pending count.
// Optional scoreboard is built only when Y86_WBS_SCOREBOARD_EN is defined.
module y86_wb_sched
    import y86_pkg::*;
#(
    parameter int         NREG  = 15,
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [3:0]      wb_dstE,
    input  logic [W-1:0]    wb_valE,
    input  logic [3:0]      wb_dstM,
    input  logic [W-1:0]    wb_valM,
    output logic            rf_we,
    output logic [3:0]      rf_waddr,
    output logic [W-1:0]    rf_wdata,
    input  logic            iss_valid,
    input  logic [3:0]      iss_dstE,
    input  logic [3:0]      iss_dstM,
    output logic [NREG-1:0] pend_mask,
    output logic            sb_err
);

    wbs_state_t state_reg, state_next;
    reg_write_t hold_reg, hold_next;
    logic       rf_we_reg, rf_we_next;
    logic [3:0] rf_waddr_reg, rf_waddr_next;
    logic [W-1:0] rf_wdata_reg, rf_wdata_next;

    logic e_ok, m_ok;
    assign e_ok = (wb_dstE != RNONE);
    assign m_ok = (wb_dstM != RNONE);

    assign wb_ready = (state_reg == IDLE);

    // State, hold register and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            hold_reg     <= '{addr: RNONE, data: '0};
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= 4'd0;
            rf_wdata_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            rf_we_reg    <= rf_we_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
        end
    end

    // Classify the accepted pair and pick the next write; M wins on equal dsts
    always_comb begin
        state_next    = state_reg;
        hold_next     = hold_reg;
        rf_we_next    = 1'b0;
        rf_waddr_next = rf_waddr_reg;
        rf_wdata_next = rf_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (wb_valid) begin
                    if (e_ok && m_ok && (wb_dstE != wb_dstM)) begin
                        rf_we_next    = 1'b1;
                        rf_waddr_next = wb_dstE;
                        rf_wdata_next = wb_valE;
                        hold_next     = '{addr: wb_dstM, data: wb_valM};
                        state_next    = SECOND;
                    end else if (m_ok) begin
                        rf_we_next    = 1'b1;
                        rf_waddr_next = wb_dstM;
                        rf_wdata_next = wb_valM;
                    end else if (e_ok) begin
                        rf_we_next    = 1'b1;
                        rf_waddr_next = wb_dstE;
                        rf_wdata_next = wb_valE;
                    end
                end
            end
            SECOND: begin
                rf_we_next    = 1'b1;
                rf_waddr_next = hold_reg.addr;
                rf_wdata_next = hold_reg.data;
                hold_next     = '{addr: RNONE, data: '0};
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rf_we    = rf_we_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;

`ifdef Y86_WBS_SCOREBOARD_EN
    logic [NREG-1:0] cnt_err;

    // One counter per register; decrement tracks the registered write port so
    // the pending bit drops on the edge the register file captures the write
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
            logic inc, dec;
            assign inc = iss_valid && ((iss_dstE == 4'(gi)) || (iss_dstM == 4'(gi)));
            assign dec = rf_we_reg && (rf_waddr_reg == 4'(gi));
            y86_sb_counter u_cnt (
                .clk     (clk),
                .rst     (rst),
                .inc     (inc),
                .dec     (dec),
                .nonzero (pend_mask[gi]),
                .err     (cnt_err[gi])
            );
        end
    endgenerate

    assign sb_err = |cnt_err;
`else
    logic unused_iss;
    assign unused_iss = ^{iss_valid, iss_dstE, iss_dstM};
    assign pend_mask  = '0;
    assign sb_err     = 1'b0;
`endif

endmodule

// File: doc/y86_wb_sched.md
# y86_wb_sched

Write-back scheduler and register scoreboard for the pipelined Y86 core. It owns the single write port of the 15-entry register file. It serialises the two write-back results (valE, valM) that one instruction can produce, e.g. popq writes both %rsp and rA. It also tracks in-flight destination registers, so decode can interlock on a pending mask instead of reading stale values.

## Interface
Parameters:
- NREG, 15, number of architectural registers (indices 0..14)
- W, 64, data width
- RNONE, 4'hF, register code meaning "no destination"

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_valid  in  1  write-back stage presents a result pair
- wb_ready  out  1  scheduler can accept this cycle
- wb_dstE  in  4  destination for valE (RNONE = none)
- wb_valE  in  W  ALU result
- wb_dstM  in  4  destination for valM (RNONE = none)
- wb_valM  in  W  memory result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  4  write address (registered)
- rf_wdata  out  W  write data (registered)
- iss_valid  in  1  decode issues an instruction
- iss_dstE  in  4  issued instruction's dstE
- iss_dstM  in  4  issued instruction's dstM
- pend_mask  out  NREG  bit i set while any write to register i is outstanding
- sb_err  out  1  sticky: counter overflow or underflow

## Operation
- FSM states: IDLE and SECOND. wb_ready = (state == IDLE), combinational.
- The accept event is wb_valid & wb_ready. Classify the accepted pair:
  - Both dsts RNONE: nothing is written.
  - Exactly one dst valid: that write is loaded into rf_*. State stays IDLE.
  - dstE == dstM, both valid: one write is loaded, carrying wb_valM (M has priority).
  - Two distinct valid dsts: the E write is loaded into rf_*. The M address/data go to a hold register. State goes to SECOND.
- In SECOND: the held M write is loaded into rf_*, the hold register is cleared, and state returns to IDLE.
- rf_we is low on every cycle without a loaded write. rf_waddr and rf_wdata hold their last values when rf_we is low.
- Scoreboard: one 2-bit saturating counter per register.
  - On iss_valid, increment dstE and dstM. If they are equal, increment once. RNONE is ignored.
  - Each cycle with rf_we = 1, decrement counter[rf_waddr].
  - If the same register is incremented and decremented in one cycle, the net change is 0.
  - pend_mask[i] = (counter[i] != 0).
  - Increment at 3 or decrement at 0 leaves the counter unchanged and sets sb_err. sb_err clears only on rst.
- Addresses 15 (RNONE) never reach rf_we. A dst in 0..14 is always valid.

## Timing
- Latency: an accept at edge t asserts rf_we for the cycle after t. The second write of a pair appears one cycle later. wb_ready is low during that second cycle.
- Throughput: one pair per cycle, except two-distinct-dst pairs, which take 2 cycles.
- A pend_mask bit clears on the same edge at which the register file captures the final write.
- Reset values: state IDLE, wb_ready 1, rf_we 0, rf_waddr 0, rf_wdata 0, hold register empty, all counters 0, pend_mask 0, sb_err 0.
- Reset asserted in SECOND discards the held M write. No partial write is emitted.
- wb_valid while wb_ready is low is ignored. The producer must hold its data.

## Configuration
- Y86_WBS_SCOREBOARD_EN defined: counters, pend_mask and sb_err are implemented as specified above.
- Y86_WBS_SCOREBOARD_EN undefined: no counters are built, iss_* is ignored, and pend_mask and sb_err are tied to 0. Write scheduling is unchanged.

## Structure
- The shared package y86_pkg holds:
  - the RNONE constant and the register index constants (RSP = 4)
  - the wbs_state_t enum {IDLE, SECOND}
  - a reg_write_t struct {addr[3:0], data[W-1:0]}
- Sub-module y86_sb_counter: one 2-bit saturating up/down counter with inc, dec, nonzero and err outputs. It is instantiated NREG times by a generate loop.

## Test plan
- Reset mid-SECOND: accept (dstE=4, dstM=0), assert rst in the next cycle -> no write to register 0 is emitted; all outputs are at reset values.
- irmovq-style pair (dstE=3, valE=0x55, dstM=F) -> one cycle later rf_we=1, waddr=3, wdata=0x55; wb_ready stays 1.
- popq pair (dstE=4, valE=0x3F8, dstM=0, valM=0xAB):
  - cycle +1: write 4 / 0x3F8, wb_ready=0
  - cycle +2: write 0 / 0xAB, wb_ready=1
- popq %rsp pair (dstE=4, dstM=4, valM=0x77) -> a single write 4 / 0x77; counter[4] is decremented once.
- Scoreboard: issue dstE=2 twice -> pend_mask[2]=1. After two writes to 2, pend_mask[2]=0. An issue and a write to 2 in the same cycle leave the count unchanged.
- Saturation: issue dstE=5 four times without write-back -> counter[5]=3, sb_err=1 and stays 1. With Y86_WBS_SCOREBOARD_EN undefined, pend_mask=0 throughout.
